adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/sad_pkg.sv | 17 +
 rtl/rr_pick.sv | 51 +++++
 rtl/adder_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_adder_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// ----------------------------------------------------------------------------
// sad_pkg
//   Shared definitions for the shared-adder arbiter: default parameter values
//   and the result-register state encoding.
// ----------------------------------------------------------------------------
package sad_pkg;

    localparam int unsigned ADD_NUM_REQ_DEF = 4;
    localparam int unsigned ADD_DATA_W_DEF  = 32;

    // EMPTY: result register holds nothing; FULL: rsp_valid is high.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } add_state_e;

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Round-robin search: finds the first set bit of req at or after ptr,
//   searching upward and wrapping at N.
//
// Parameters
//   N   number of request lines
//   IW  width of ptr / gnt_idx
// Ports
//   req      in   N   request vector
//   ptr      in   IW  search start index (always < N)
//   gnt      out  N   one-hot of the selected request, zero if none
//   gnt_idx  out  IW  index of the selected request, zero if none
//   gnt_any  out  1   some request was found
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    int unsigned idx;
    logic [IW-1:0] idx_w;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // Candidate position ptr+k, folded back into 0..N-1.
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = IW'(idx);
            if (!gnt_any && req[idx_w]) begin
                gnt[idx_w] = 1'b1;
                gnt_idx    = idx_w;
                gnt_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// ----------------------------------------------------------------------------
// adder_arbiter
//   NUM_REQ requesters share one DATA_W-bit adder. A round-robin arbiter grants
//   one requester per cycle; its A+B lands in a single result register one
//   cycle later. The result register can drain and refill in the same cycle,
//   giving one sum per cycle while rsp_ready stays high.
//
// Configuration
//   ADDER_ARBITER_CARRY_EN  when defined, adds rsp_carry (bit DATA_W of the
//                           full sum, registered alongside rsp_sum). When
//                           undefined the carry is dropped.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   DATA_W   operand / sum width
// Ports
//   Clk        in   1                sole clock, rising edge
//   Rst        in   1                asynchronous active-high reset
//   req_valid  in   NUM_REQ          per-requester operand valid
//   req_a      in   NUM_REQ*DATA_W   operand A, slice i for requester i
//   req_b      in   NUM_REQ*DATA_W   operand B, slice i for requester i
//   req_ready  out  NUM_REQ          one-hot grant
//   rsp_valid  out  1                result register holds a valid sum
//   rsp_ready  in   1                consumer accepts the result
//   rsp_carry  out  1                carry-out (ADDER_ARBITER_CARRY_EN only)
//   rsp_sum    out  DATA_W           registered A+B mod 2^DATA_W
//   rsp_id     out  clog2(NUM_REQ)   owner of rsp_sum
// ----------------------------------------------------------------------------
module adder_arbiter
    import sad_pkg::*;
#(
    parameter int unsigned NUM_REQ = ADD_NUM_REQ_DEF,
    parameter int unsigned DATA_W  = ADD_DATA_W_DEF
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
`ifdef ADDER_ARBITER_CARRY_EN
    output logic                        rsp_carry,
`endif
    output logic [DATA_W-1:0]           rsp_sum,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    add_state_e        state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q;
    logic [DATA_W-1:0] sum_q;
    logic [IDW-1:0]    id_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic               grant_ok;
    logic               fire;
    logic [IDW-1:0]     ptr_inc;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // A grant may be issued into an empty register, or into a full one that is
    // being drained this same cycle. Rst is folded in so req_ready stays low
    // for the whole reset window, not just after the next edge.
    assign grant_ok = !Rst && ((state_q == ST_EMPTY) || rsp_ready);
    assign fire     = grant_ok && pick_any;

    // Pointer moves to the requester after the winner, wrapping at NUM_REQ.
    always_comb begin
        if (pick_idx == IDW'(NUM_REQ - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = pick_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Shared adder: operand mux driven by the grant index only
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic [DATA_W-1:0] sum_next;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                a_sel = req_a[i*DATA_W +: DATA_W];
                b_sel = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ADDER_ARBITER_CARRY_EN
    logic [DATA_W:0] sum_wide;
    logic            carry_next;
    logic            carry_q;

    assign sum_wide   = {1'b0, a_sel} + {1'b0, b_sel};
    assign sum_next   = sum_wide[DATA_W-1:0];
    assign carry_next = sum_wide[DATA_W];
    assign rsp_carry  = carry_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            carry_q <= 1'b0;
        end else if (fire) begin
            carry_q <= carry_next;
        end
    end
`else
    // Carry-out is intentionally discarded: the sum wraps mod 2^DATA_W.
    assign sum_next = a_sel + b_sel;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (fire) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // Held while the consumer stalls; drain empties unless refilled.
                if (rsp_ready) begin
                    state_d = fire ? ST_FULL : ST_EMPTY;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        rsp_valid = (state_q == ST_FULL);
        req_ready = fire ? pick_gnt : '0;
    end

    // ------------------------------------------------------------------
    // Result register and round-robin pointer; both update only on a grant
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sum_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else if (fire) begin
            sum_q    <= sum_next;
            id_q     <= pick_idx;
            rr_ptr_q <= ptr_inc;
        end
    end

    assign rsp_sum = sum_q;
    assign rsp_id  = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// ----------------------------------------------------------------------------
// tb_adder_arbiter
//   Directed, table-driven bench for adder_arbiter (NUM_REQ=4, DATA_W=32).
//   Each table row is one clock cycle: inputs, the expected combinational
//   grant, and the expected registered outputs after the following edge.
//   Mid-operation reset is exercised by a hand-written sequence.
// ----------------------------------------------------------------------------
module tb_adder_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned NV = 17;

    logic            Clk;
    logic            Rst;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_sum;
    logic [1:0]      rsp_id;
`ifdef ADDER_ARBITER_CARRY_EN
    logic            rsp_carry;
`endif

    adder_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
`ifdef ADDER_ARBITER_CARRY_EN
        .rsp_carry (rsp_carry),
`endif
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [NR-1:0]    valid;
        logic [NR*DW-1:0] a;
        logic [NR*DW-1:0] b;
        logic             rdy;
        logic [NR-1:0]    gnt;    // expected req_ready this cycle
        logic             rv;     // expected outputs after the edge
        logic [DW-1:0]    sum;
        logic [1:0]       id;
        logic             carry;
    } vec_t;

    vec_t vecs [NV];

    int checks;
    int passes;

    function automatic vec_t mk(input logic [NR-1:0] valid, input logic [NR*DW-1:0] a,
                                input logic [NR*DW-1:0] b, input logic rdy,
                                input logic [NR-1:0] gnt, input logic rv,
                                input logic [DW-1:0] sum, input logic [1:0] id,
                                input logic carry);
        vec_t v;
        v.valid = valid;
        v.a     = a;
        v.b     = b;
        v.rdy   = rdy;
        v.gnt   = gnt;
        v.rv    = rv;
        v.sum   = sum;
        v.id    = id;
        v.carry = carry;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [NR*DW-1:0] a_rr, b_rr, a_one, b_one, a_wrap, b_wrap, a_16, b_16, a_bp, b_bp;

    initial begin
        checks = 0;
        passes = 0;

        // Sums per requester: 11, 22, 33, 44.
        a_rr   = {32'd40, 32'd30, 32'd20, 32'd10};
        b_rr   = {32'd4,  32'd3,  32'd2,  32'd1};
        a_one  = {32'd0, 32'd0, 32'd0, 32'd5};
        b_one  = {32'd0, 32'd0, 32'd0, 32'd7};
        a_wrap = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
        b_wrap = {32'd0, 32'd0, 32'd0, 32'h0000_0002};
        a_16   = {32'd0, 32'd0, 32'd0, 32'd8};
        b_16   = {32'd0, 32'd0, 32'd0, 32'd8};
        a_bp   = {32'd0, 32'd0, 32'd100, 32'd8};
        b_bp   = {32'd0, 32'd0, 32'd1,   32'd8};

        //               valid    a       b       rdy   gnt      rv    sum   id    carry
        vecs[0]  = mk(4'b0000, a_rr,   b_rr,   1'b1, 4'b0000, 1'b0, 32'd0,   2'd0, 1'b0);
        // Round robin from reset: 0,1,2,3,0
        vecs[1]  = mk(4'b1111, a_rr,   b_rr,   1'b1, 4'b0001, 1'b1, 32'd11,  2'd0, 1'b0);
        vecs[2]  = mk(4'b1111, a_rr,   b_rr,   1'b1, 4'b0010, 1'b1, 32'd22,  2'd1, 1'b0);
        vecs[3]  = mk(4'b1111, a_rr,   b_rr,   1'b1, 4'b0100, 1'b1, 32'd33,  2'd2, 1'b0);
        vecs[4]  = mk(4'b1111, a_rr,   b_rr,   1'b1, 4'b1000, 1'b1, 32'd44,  2'd3, 1'b0);
        vecs[5]  = mk(4'b1111, a_rr,   b_rr,   1'b1, 4'b0001, 1'b1, 32'd11,  2'd0, 1'b0);
        // Drain with nothing pending: EMPTY, sum/id hold
        vecs[6]  = mk(4'b0000, a_rr,   b_rr,   1'b1, 4'b0000, 1'b0, 32'd11,  2'd0, 1'b0);
        // rr_ptr=1, 1001: skip idle to 3, then wrap to 0
        vecs[7]  = mk(4'b1001, a_rr,   b_rr,   1'b1, 4'b1000, 1'b1, 32'd44,  2'd3, 1'b0);
        vecs[8]  = mk(4'b1001, a_rr,   b_rr,   1'b1, 4'b0001, 1'b1, 32'd11,  2'd0, 1'b0);
        vecs[9]  = mk(4'b0000, a_rr,   b_rr,   1'b1, 4'b0000, 1'b0, 32'd11,  2'd0, 1'b0);
        // Single request 5+7
        vecs[10] = mk(4'b0001, a_one,  b_one,  1'b1, 4'b0001, 1'b1, 32'd12,  2'd0, 1'b0);
        // Wrap: FFFFFFFF+2 -> 1, carry 1
        vecs[11] = mk(4'b0001, a_wrap, b_wrap, 1'b1, 4'b0001, 1'b1, 32'd1,   2'd0, 1'b1);
        // Load 0x10, then backpressure 3 cycles with requester 1 waiting
        vecs[12] = mk(4'b0001, a_16,   b_16,   1'b1, 4'b0001, 1'b1, 32'h10,  2'd0, 1'b0);
        vecs[13] = mk(4'b0010, a_bp,   b_bp,   1'b0, 4'b0000, 1'b1, 32'h10,  2'd0, 1'b0);
        vecs[14] = mk(4'b0010, a_bp,   b_bp,   1'b0, 4'b0000, 1'b1, 32'h10,  2'd0, 1'b0);
        vecs[15] = mk(4'b0010, a_bp,   b_bp,   1'b0, 4'b0000, 1'b1, 32'h10,  2'd0, 1'b0);
        vecs[16] = mk(4'b0010, a_bp,   b_bp,   1'b1, 4'b0010, 1'b1, 32'd101, 2'd1, 1'b0);

        // Reset state, with requests pending to show req_ready is forced low.
        Rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = a_rr;
        req_b     = b_rr;
        rsp_ready = 1'b1;
        #1;
        check("reset req_ready", 64'(req_ready), 64'd0);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_sum",   64'(rsp_sum),   64'd0);
        check("reset rsp_id",    64'(rsp_id),    64'd0);
        @(posedge Clk);
        #1;
        check("reset-edge req_ready", 64'(req_ready), 64'd0);
        Rst = 1'b0;

        for (int i = 0; i < int'(NV); i++) begin
            req_valid = vecs[i].valid;
            req_a     = vecs[i].a;
            req_b     = vecs[i].b;
            rsp_ready = vecs[i].rdy;
            #1;
            check($sformatf("row%0d req_ready", i), 64'(req_ready), 64'(vecs[i].gnt));
            @(posedge Clk);
            #1;
            check($sformatf("row%0d rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].rv));
            check($sformatf("row%0d rsp_sum", i),   64'(rsp_sum),   64'(vecs[i].sum));
            check($sformatf("row%0d rsp_id", i),    64'(rsp_id),    64'(vecs[i].id));
`ifdef ADDER_ARBITER_CARRY_EN
            check($sformatf("row%0d rsp_carry", i), 64'(rsp_carry), 64'(vecs[i].carry));
`endif
        end

        // Mid-operation reset: FULL with rr_ptr=2, stalled consumer.
        req_valid = 4'b1111;
        req_a     = a_rr;
        req_b     = b_rr;
        rsp_ready = 1'b0;
        #2;
        Rst = 1'b1;
        #1;
        check("midrst rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst req_ready", 64'(req_ready), 64'd0);
        check("midrst rsp_sum",   64'(rsp_sum),   64'd0);
        check("midrst rsp_id",    64'(rsp_id),    64'd0);
        @(posedge Clk);
        #1;
        check("midrst-edge rsp_valid", 64'(rsp_valid), 64'd0);
        Rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("postrst first grant", 64'(req_ready), 64'b0001);
        @(posedge Clk);
        #1;
        check("postrst rsp_valid", 64'(rsp_valid), 64'd1);
        check("postrst rsp_sum",   64'(rsp_sum),   64'd11);
        check("postrst rsp_id",    64'(rsp_id),    64'd0);
        check("postrst second grant", 64'(req_ready), 64'b0010);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
